// File: rtl/membus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter.
package membus_arb_pkg;

    // Default bus geometry; interface and arbiter instances normally keep these.
    localparam int unsigned MEMBUS_DATA_WIDTH = 32;
    localparam int unsigned MEMBUS_ADDR_WIDTH = 32;

    // Arbiter FSM: either free to accept, or holding the bus for one response.
    typedef enum logic {
        Idle     = 1'b0,
        WaitResp = 1'b1
    } arb_state_t;

    // Identifies a master: instruction fetch or load/store.
    typedef enum logic {
        OwnerI = 1'b0,
        OwnerD = 1'b1
    } arb_owner_t;

    // The master that is not `o`; used to rotate round-robin priority.
    function automatic arb_owner_t other_owner(input arb_owner_t o);
        return (o == OwnerI) ? OwnerD : OwnerI;
    endfunction

endpackage

// File: rtl/membus_arbiter_if.sv
// Memory bus: valid/ready request channel plus a single-beat rvalid/rdata response.
interface membus_if #(
    parameter int unsigned DATA_WIDTH = membus_arb_pkg::MEMBUS_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = membus_arb_pkg::MEMBUS_ADDR_WIDTH
);
    logic                      valid;
    logic                      ready;
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      wen;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wmask;
    logic                      rvalid;
    logic [DATA_WIDTH-1:0]     rdata;

    // Requester side.
    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    // Responder side.
    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/membus_arbiter_rr_arbiter2.sv
// Combinational two-way picker: priority decides only when both masters request.
module rr_arbiter2
    import membus_arb_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  arb_owner_t prio,
    input  logic       fixed,
    output logic       gnt_i,
    output logic       gnt_d,
    output logic       contested
);

    arb_owner_t w_winner;

    // Resolve a conflict in favour of D when fixed, otherwise the current priority holder.
    always_comb begin
        contested = req_i && req_d;
        w_winner  = fixed ? OwnerD : prio;
        gnt_i     = req_i && (!req_d || (w_winner == OwnerI));
        gnt_d     = req_d && (!req_i || (w_winner == OwnerD));
    end

endmodule

// File: rtl/membus_arbiter.sv
// Merges instruction-fetch and load/store masters onto one memory port,
// one outstanding transaction at a time, responses routed back to the issuer.
module membus_arbiter
    import membus_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic     clk,
    input  logic     rst,
    membus_if.slave  i_membus,
    membus_if.slave  d_membus,
    membus_if.master mem_membus
);

    arb_state_t r_state;
    arb_owner_t r_owner;
    arb_owner_t r_prio;

    logic                    w_fixed;
    logic                    w_gnt_i;
    logic                    w_gnt_d;
    logic                    w_contested;
    logic                    w_idle;
    logic                    w_wait;
    logic                    w_hs;
    arb_owner_t              w_granted;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_wen;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH/8-1:0] w_wmask;

    assign w_fixed = (FIXED_PRIORITY != 0);

    rr_arbiter2 u_pick (
        .req_i     (i_membus.valid),
        .req_d     (d_membus.valid),
        .prio      (r_prio),
        .fixed     (w_fixed),
        .gnt_i     (w_gnt_i),
        .gnt_d     (w_gnt_d),
        .contested (w_contested)
    );

    // Phase qualifiers include rst so every handshake output reads 0 while reset is held.
    assign w_idle = rst && (r_state == Idle);
    assign w_wait = rst && (r_state == WaitResp);

    // Request mux: D is the default source when nothing is granted.
    always_comb begin
        w_granted = w_gnt_i ? OwnerI : OwnerD;
        if (w_gnt_i) begin
            w_addr  = i_membus.addr;
            w_wen   = i_membus.wen;
            w_wdata = i_membus.wdata;
            w_wmask = i_membus.wmask;
        end else begin
            w_addr  = d_membus.addr;
            w_wen   = d_membus.wen;
            w_wdata = d_membus.wdata;
            w_wmask = d_membus.wmask;
        end
    end

    assign mem_membus.valid = w_idle && (w_gnt_i || w_gnt_d);
    assign mem_membus.addr  = w_addr;
    assign mem_membus.wen   = w_wen;
    assign mem_membus.wdata = w_wdata;
    assign mem_membus.wmask = w_wmask;

    assign w_hs = mem_membus.valid && mem_membus.ready;

    assign i_membus.ready = w_idle && w_gnt_i && mem_membus.ready;
    assign d_membus.ready = w_idle && w_gnt_d && mem_membus.ready;

    // Responses outside WaitResp are stray and never reach either master.
    assign i_membus.rvalid = w_wait && (r_owner == OwnerI) && mem_membus.rvalid;
    assign d_membus.rvalid = w_wait && (r_owner == OwnerD) && mem_membus.rvalid;
    assign i_membus.rdata  = mem_membus.rdata;
    assign d_membus.rdata  = mem_membus.rdata;

    // Arbitration FSM: latch owner on handshake, rotate priority on contested grants.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= Idle;
            r_owner <= OwnerD;
            r_prio  <= OwnerD;
        end else begin
            case (r_state)
                Idle: begin
                    if (w_hs) begin
                        r_state <= WaitResp;
                        r_owner <= w_granted;
                        if (w_contested && !w_fixed) begin
                            r_prio <= other_owner(w_granted);
                        end
                    end
                end
                WaitResp: begin
                    if (mem_membus.rvalid) begin
                        r_state <= Idle;
                    end
                end
                default: r_state <= Idle;
            endcase
        end
    end

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Two-master to one-slave arbiter on `membus_if`.
- Merges the instruction-fetch port (`i_membus`) and the load/store port (`d_membus`) onto the single port of the shared `memory` block, so it sits directly upstream of memory.
- Allows one outstanding transaction at a time.
- Routes each response (`rvalid`/`rdata`) back only to the master that issued the request.

Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin between I and D on conflict; 1 = D always wins.
- DATA_WIDTH, 32, must match `membus_if` and memory DATA_WIDTH.
- ADDR_WIDTH, 32, `membus_if` address width; the slave uses only the low bits.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- i_membus  membus_if.slave  -  instruction master side (`valid`, `ready`, `addr`, `wen`, `wdata`, `wmask`, `rvalid`, `rdata`).
- d_membus  membus_if.slave  -  data master side, same signals.
- mem_membus  membus_if.master  -  to the memory slave.

Behaviour:
- Registered state:
  - `state` ∈ {Idle, WaitResp}.
  - `owner` ∈ {OwnerI, OwnerD}.
  - `prio` ∈ {OwnerI, OwnerD}.
- Reset (`rst`==0, async): `state`=Idle, `owner`=OwnerD, `prio`=OwnerD.
  - While `rst`==0, these are forced to 0: `mem_membus.valid`, `i/d_membus.ready`, `i/d_membus.rvalid`.
- Grant (combinational, Idle only):
  - Only one master valid → that master is granted.
  - Both valid → grant `prio` (FIXED_PRIORITY=1: always D).
  - Neither valid → no grant; `mem_membus.valid`=0.
- Forwarding in Idle:
  - The granted master's `addr`, `wen`, `wdata`, `wmask` drive `mem_membus`.
  - `mem_membus.valid` = granted master's `valid`.
  - Granted master's `ready` = `mem_membus.ready`; the non-granted master's `ready` = 0.
- Handshake = `mem_membus.valid && mem_membus.ready` in Idle. On the next edge:
  - `state`←WaitResp.
  - `owner`←granted master.
  - If arbitration was contested and FIXED_PRIORITY=0, `prio`←the other master. Otherwise `prio` is unchanged.
- WaitResp:
  - `mem_membus.valid`=0; both masters' `ready`=0.
  - When `mem_membus.rvalid`=1: `owner`'s `rvalid`=1 in the same cycle (combinational), and `state`←Idle on the next edge.
- `rdata`: `mem_membus.rdata` is broadcast to both masters; only `rvalid` is gated by `owner`.
- Latency, request accept at cycle 0 with memory ready:
  - Read: `rvalid` at cycle 1; next accept possible at cycle 2.
  - Write: memory returns `rvalid` at cycle 2; next accept at cycle 3.
  - The arbiter adds no register stage on the request or response paths.
- Boundary conditions:
  - `mem_membus.rvalid` in Idle (stray response, or in flight across a reset) is dropped; neither master sees `rvalid`.
  - `mem_membus.ready`=0 in Idle: no handshake, `state`/`owner`/`prio` unchanged, and the grant is re-evaluated next cycle.
  - Masters hold request fields stable while `valid` && !`ready`.
  - A request raised in WaitResp waits; it may be granted in the first Idle cycle.
  - Reset asserted in WaitResp: returns to Idle immediately, and the pending response is discarded.

Decomposition:
- Package `membus_arb_pkg`:
  - `arb_state_t` enum {Idle, WaitResp}, 1 bit.
  - `arb_owner_t` enum {OwnerI, OwnerD}, 1 bit.
- Sub-module `rr_arbiter2`: combinational 2-way picker.
  - Inputs: `req_i`, `req_d`, `prio`, `fixed`.
  - Outputs: `gnt_i`, `gnt_d`, `contested`.
- Top module: FSM, owner/prio registers, muxing.

Test Plan:
- Reset then I-only read of addr 0x4 (mem[1]=0xDEADBEEF) → `i.ready`=1 at cycle 0; `i.rvalid`=1 with `rdata`=0xDEADBEEF at cycle 1; `d.rvalid` stays 0.
- D write `addr`=0x8, `wdata`=0x12345678, `wmask`=4'b0011 over old 0xAAAAAAAA, then an I read of 0x8 → `d.rvalid` at cycle 2; I read accepted at cycle 3 returns 0xAAAA5678.
- I and D both valid every cycle, FIXED_PRIORITY=0 → grants alternate D, I, D, I, starting with D after reset. With FIXED_PRIORITY=1, I is never granted while D is valid.
- D read issued while I is waiting → `i.ready`=0 throughout D's WaitResp; I is accepted in the cycle immediately after D's `rvalid`.
- Stray `mem_membus.rvalid`=1 forced in Idle → `i.rvalid`=`d.rvalid`=0 and `state` stays Idle.
- `rst` pulsed low in WaitResp after a D read accept → all ready/rvalid outputs read 0 during reset; the later memory `rvalid` is ignored; a fresh I read then completes normally with 1-cycle latency.
